// File: rtl/matrix_vector_sequencer_if.sv
// Bus bundle between the matrix-vector sequencer, its matrix row store, the
// pipelined dot-product datapath and the result consumer.
interface matrix_vector_sequencer_if #(
  parameter int data_width = 3,
  parameter int n_columns  = 3,
  parameter int m_rows     = 3
);
  localparam int res_width  = 2*data_width + $clog2(n_columns+1);
  localparam int addr_width = (m_rows > 1) ? $clog2(m_rows) : 1;

  logic                            start;
  logic [n_columns*data_width-1:0] vec_in;
  logic                            busy;
  logic                            rd_en;
  logic [addr_width-1:0]           row_addr;
  logic [n_columns*data_width-1:0] row_data;
  logic                            dp_valid;
  logic [n_columns*data_width-1:0] dp_row;
  logic [n_columns*data_width-1:0] dp_vec;
  logic                            dp_res_valid;
  logic [res_width-1:0]            dp_res;
  // out_valid/out_ready: outp transfers on a rising edge where both are high;
  // once raised, out_valid and outp hold until that edge, and out_ready may be
  // driven independently of out_valid.
  logic                            out_valid;
  logic                            out_ready;
  logic [m_rows*res_width-1:0]     outp;
  logic                            err;

  modport master (
    input  start, vec_in, row_data, dp_res_valid, dp_res, out_ready,
    output busy, rd_en, row_addr, dp_valid, dp_row, dp_vec, out_valid, outp, err
  );

  modport slave (
    output start, vec_in, row_data, dp_res_valid, dp_res, out_ready,
    input  busy, rd_en, row_addr, dp_valid, dp_row, dp_vec, out_valid, outp, err
  );
endinterface

// File: rtl/matrix_vector_sequencer.sv
// Sequences one matrix-vector product: streams matrix rows to an external
// dot-product pipeline and gathers results. Optional macro: MVM_SEQ_ERR_CHECK_EN.
module matrix_vector_sequencer #(
  parameter int data_width = 3,
  parameter int n_columns  = 3,
  parameter int m_rows     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  matrix_vector_sequencer_if.master bus,
  output logic [1:0]                fsm_state
);
  localparam int res_width  = 2*data_width + $clog2(n_columns+1);
  localparam int addr_width = (m_rows > 1) ? $clog2(m_rows) : 1;
  localparam int cnt_width  = $clog2(m_rows+1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                          state;
  logic                            rd_en_q;
  logic                            dp_valid_q;
  logic                            out_valid_q;
  logic [addr_width-1:0]           row_addr_q;
  logic [cnt_width-1:0]            count;
  logic [n_columns*data_width-1:0] dp_vec_q;
  logic [m_rows*res_width-1:0]     outp_q;
  logic                            res_accept;

  // Results are only collected while a product is in flight and slots remain.
  assign res_accept = bus.dp_res_valid && (state == FETCH || state == DRAIN) &&
                      (count < cnt_width'(m_rows));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rd_en_q     <= 1'b0;
      dp_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      row_addr_q  <= '0;
      count       <= '0;
      dp_vec_q    <= '0;
      outp_q      <= '0;
    end else begin
      dp_valid_q <= rd_en_q;
      case (state)
        IDLE: if (bus.start) begin
          dp_vec_q   <= bus.vec_in;
          count      <= '0;
          rd_en_q    <= 1'b1;
          row_addr_q <= '0;
          state      <= FETCH;
        end
        FETCH: begin
          if (row_addr_q == addr_width'(m_rows-1)) begin
            rd_en_q <= 1'b0;
            state   <= DRAIN;
          end else begin
            row_addr_q <= row_addr_q + 1'b1;
          end
        end
        DRAIN: ;
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // The last result wins over the FETCH/DRAIN transitions above.
      if (res_accept) begin
        for (int i = 0; i < m_rows; i++) begin
          if (count == cnt_width'(i)) outp_q[i*res_width +: res_width] <= bus.dp_res;
        end
        count <= count + 1'b1;
        if (count == cnt_width'(m_rows-1)) begin
          rd_en_q     <= 1'b0;
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
      end
    end
  end

`ifdef MVM_SEQ_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (bus.dp_res_valid &&
                 (state == IDLE || state == DONE || count == cnt_width'(m_rows))) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy      = (state != IDLE);
  assign bus.rd_en     = rd_en_q;
  assign bus.row_addr  = row_addr_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_row    = bus.row_data;
  assign bus.dp_vec    = dp_vec_q;
  assign bus.out_valid = out_valid_q;
  assign bus.outp      = outp_q;
  assign fsm_state     = state;
endmodule

// File: tb/tb_matrix_vector_sequencer.sv
// Scoreboarded bench for matrix_vector_sequencer with a row store and a
// two-stage dot-product datapath model around it.
module tb_matrix_vector_sequencer;
  localparam int DW = 3;
  localparam int NC = 3;
  localparam int MR = 3;
  localparam int RW = 8;
  localparam int VW = NC*DW;
  localparam int OW = MR*RW;
`ifdef MVM_SEQ_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_vector_sequencer_if #(.data_width(DW), .n_columns(NC), .m_rows(MR)) bus();
  logic [1:0] fsm_state;

  matrix_vector_sequencer #(.data_width(DW), .n_columns(NC), .m_rows(MR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- environment models ----------------
  logic [VW-1:0] mat [MR];
  initial begin
    mat[0] = {3'd3, 3'd2, 3'd1};
    mat[1] = {3'd6, 3'd5, 3'd4};
    mat[2] = {3'd1, 3'd0, 3'd7};
  end

  always @(posedge clk) if (bus.rd_en) bus.row_data <= mat[bus.row_addr];

  function automatic logic [RW-1:0] dot(input logic [VW-1:0] r, input logic [VW-1:0] v);
    logic [RW-1:0] s;
    s = '0;
    for (int k = 0; k < NC; k++) s = s + RW'(r[k*DW +: DW]) * RW'(v[k*DW +: DW]);
    return s;
  endfunction

  logic          p1_v = 1'b0, p2_v = 1'b0;
  logic [RW-1:0] p1_d = '0, p2_d = '0;
  logic          inj_v = 1'b0;
  logic [RW-1:0] inj_d = '0;
  always @(posedge clk) begin
    p1_v <= bus.dp_valid;
    p1_d <= dot(bus.dp_row, bus.dp_vec);
    p2_v <= p1_v;
    p2_d <= p1_d;
  end
  assign bus.dp_res_valid = p2_v | inj_v;
  assign bus.dp_res       = inj_v ? inj_d : p2_d;

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [OW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected none", bus.outp);
      end else begin
        chk("sb_outp", 64'(bus.outp), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input logic [VW-1:0] v, input logic [OW-1:0] e,
                        input int hold, input bit chg, input int bs, input bit chk_hist);
    int rd_total = 0;
    int ov_first = -1;
    int ov_n = 0;
    bit hs = 0, done = 0, stable_bad = 0, vec_bad = 0;
    logic [OW-1:0] snap = '0;
    logic [15:0] hist = '0;
    @(posedge clk); #1;
    bus.vec_in = v;
    bus.start = 1'b1;
    exp_q.push_back(e);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c < 16) hist[c] = bus.rd_en;
      rd_total += int'(bus.rd_en);
      if (bus.busy && bus.dp_vec !== v) vec_bad = 1;
      if (bus.out_valid) begin
        if (ov_first < 0) begin ov_first = c; snap = bus.outp; end
        else if (bus.outp !== snap) stable_bad = 1;
        ov_n++;
        hs = bus.out_ready;
      end else if (ov_first >= 0) begin
        stable_bad = 1;
      end
      @(posedge clk); #1;
      if (c == 0) begin bus.start = 1'b0; if (chg) bus.vec_in = ~v; end
      if (c == bs-1) bus.start = 1'b1;
      if (c == bs) bus.start = 1'b0;
      if (hs) begin bus.out_ready = 1'b0; done = 1; end
      else if (ov_n > hold) bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_rd_cnt"}, 64'(rd_total), 64'd3);
    chk({tag, "_ov_cycle"}, 64'(ov_first), 64'd7);
    chk({tag, "_hold_stable"}, 64'(stable_bad), 64'd0);
    chk({tag, "_vec_stable"}, 64'(vec_bad), 64'd0);
    chk({tag, "_idle_after"}, 64'({fsm_state, bus.out_valid, bus.busy}), 64'd0);
    chk({tag, "_err"}, 64'(bus.err), 64'd0);
    if (chk_hist) chk({tag, "_rd_pattern"}, 64'(hist[7:0]), 64'h0e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({bus.busy, bus.rd_en, bus.dp_valid, bus.out_valid, bus.err}), 64'd0);
    chk({tag, "_data"}, 64'({bus.row_addr, bus.dp_vec, bus.outp}), 64'd0);
    chk({tag, "_state"}, 64'(fsm_state), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [VW-1:0] VEC_A = {3'd2, 3'd1, 3'd1};
  localparam logic [VW-1:0] VEC_B = {3'd1, 3'd3, 3'd2};
  localparam logic [VW-1:0] VEC_C = {3'd7, 3'd7, 3'd7};
  localparam logic [VW-1:0] VEC_D = {3'd4, 3'd5, 3'd0};
  localparam logic [OW-1:0] RES_A = {8'd9,  8'd21,  8'd9};
  localparam logic [OW-1:0] RES_B = {8'd15, 8'd29,  8'd11};
  localparam logic [OW-1:0] RES_C = {8'd56, 8'd105, 8'd42};
  localparam logic [OW-1:0] RES_D = {8'd4,  8'd49,  8'd22};

  initial begin
    bus.start = 1'b0;
    bus.vec_in = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("basic",   VEC_A, RES_A, 0, 1'b0, -1, 1'b1);
    run_op("backpr",  VEC_B, RES_B, 5, 1'b1, -1, 1'b0);
    run_op("busy_st", VEC_C, RES_C, 1, 1'b0,  2, 1'b0);
    run_op("plain",   VEC_D, RES_D, 2, 1'b0, -1, 1'b0);

    // Stray result while idle
    @(posedge clk); #1;
    inj_v = 1'b1;
    inj_d = 8'haa;
    @(posedge clk); #1;
    inj_v = 1'b0;
    @(negedge clk);
    chk("stray_err", 64'(bus.err), 64'(ERR_EN));
    chk("stray_outp", 64'(bus.outp), 64'(RES_D));
    chk("stray_state", 64'(fsm_state), 64'd0);

    // Reset in cycle 4 of an operation
    @(posedge clk); #1;
    bus.vec_in = VEC_B;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_inflight_err", 64'(bus.err), 64'(ERR_EN));
    chk("mid_outp", 64'(bus.outp), 64'd0);
    chk("mid_idle", 64'({fsm_state, bus.busy, bus.out_valid}), 64'd0);

    // Recovery after a clean reset
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("recover", VEC_A, RES_A, 0, 1'b0, -1, 1'b0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
